// File: rtl/aes256_encrypt_core_pkg.sv
// ---------------------------------------------------------------------------
// aes256_encrypt_core_pkg
//
// Shared definitions for the iterative AES-256 encryption core:
//   - AES_NR         : number of AES-256 rounds (14)
//   - round_keys_t   : the 15 expanded round keys, index 0 = whitening key
//   - state_t        : control states of the encryption core
//   - SBOX           : forward AES S-box
//   - xtime/gf_mul3  : GF(2^8) multiply-by-2 and multiply-by-3 helpers
//
// Byte ordering follows FIPS-197: byte 0 of a 128-bit block is bits
// [127:120], and bytes fill the 4x4 state column by column.
// ---------------------------------------------------------------------------
package aes256_encrypt_core_pkg;

    localparam int AES_NR = 14;

    // Packed so a whole key schedule can travel on a single port.
    typedef logic [AES_NR:0][127:0] round_keys_t;

    // OUTREG_S is only reachable when the output register build option is
    // enabled; the encoding is shared by both builds.
    typedef enum logic [1:0] {
        IDLE_S   = 2'd0,
        ROUND_S  = 2'd1,
        OUTREG_S = 2'd2,
        OUT_S    = 2'd3
    } state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Multiply by x (i.e. by 2) in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by 3 in GF(2^8): 3*b = 2*b + b.
    function automatic logic [7:0] gf_mul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

endpackage

// File: rtl/aes_enc_round.sv
// ---------------------------------------------------------------------------
// aes_enc_round
//
// One combinational AES encryption round, shared by all 14 rounds of the
// iterative core.
//
// Ports:
//   state        in  128  current cipher state (byte 0 = bits [127:120])
//   round_key    in  128  round key applied by AddRoundKey
//   final_round  in  1    1 = skip MixColumns (last AES round)
//   next_state   out 128  SubBytes -> ShiftRows -> [MixColumns] -> AddRoundKey
// ---------------------------------------------------------------------------
module aes_enc_round
    import aes256_encrypt_core_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] round_key,
    input  logic         final_round,
    output logic [127:0] next_state
);

    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            sb[i] = SBOX[state[127-8*i -: 8]];
        end
    end

    // Byte index is row + 4*column; row r rotates left by r columns.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[r+4*c] = sb[r + 4*((c + r) % 4)];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            mc[4*c+0] = xtime(sr[4*c+0]) ^ gf_mul3(sr[4*c+1]) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c+0] ^ xtime(sr[4*c+1]) ^ gf_mul3(sr[4*c+2]) ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c+0] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ gf_mul3(sr[4*c+3]);
            mc[4*c+3] = gf_mul3(sr[4*c+0]) ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
        end
    end

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            next_state[127-8*i -: 8] = (final_round ? sr[i] : mc[i]) ^ round_key[127-8*i -: 8];
        end
    end

endmodule

// File: rtl/aes256_encrypt_core.sv
// ---------------------------------------------------------------------------
// aes256_encrypt_core
//
// Iterative AES-256 encryption engine. Captures the 15 expanded round keys
// while idle, accepts one plaintext block per valid/ready handshake, performs
// the whitening AddRoundKey on acceptance and then one round per clock, and
// holds the ciphertext on a valid/ready output until the sink takes it.
//
// Parameters:
//   NUM_ROUNDS  round count, must be 14
//   DATA_WIDTH  block width, must be 128
//
// Ports:
//   clk                 in   1             clock
//   resetn              in   1             synchronous active-low reset
//   round_keys_i        in   round_keys_t  expanded keys, [0] = whitening key
//   round_keys_valid_i  in   1             keys valid (level); captured in IDLE_S
//   pt_data_i           in   128           plaintext block
//   pt_valid_i          in   1             plaintext valid
//   pt_ready_o          out  1             core can accept plaintext
//   ct_data_o           out  128           ciphertext block
//   ct_valid_o          out  1             ciphertext valid
//   ct_ready_i          in   1             sink accepts ciphertext
//   busy_o              out  1             block in flight or waiting at output
//
// Build option:
//   AES_ENC_OUT_REG_EN  adds OUTREG_S and a dedicated ciphertext register,
//                       isolating ct_data_o from the round logic at the cost
//                       of one extra cycle of latency.
// ---------------------------------------------------------------------------
module aes256_encrypt_core
    import aes256_encrypt_core_pkg::*;
#(
    parameter int NUM_ROUNDS = 14,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  round_keys_t           round_keys_i,
    input  logic                  round_keys_valid_i,
    input  logic [DATA_WIDTH-1:0] pt_data_i,
    input  logic                  pt_valid_i,
    output logic                  pt_ready_o,
    output logic [DATA_WIDTH-1:0] ct_data_o,
    output logic                  ct_valid_o,
    input  logic                  ct_ready_i,
    output logic                  busy_o
);

    if (NUM_ROUNDS != AES_NR) begin : g_bad_num_rounds
        $error("aes256_encrypt_core: NUM_ROUNDS must be 14");
    end

    if (DATA_WIDTH != 128) begin : g_bad_data_width
        $error("aes256_encrypt_core: DATA_WIDTH must be 128");
    end

    localparam logic [3:0] LAST_ROUND = 4'(AES_NR);

    state_t       state;
    state_t       state_next;
    round_keys_t  key_store;
    logic         keys_loaded;
    logic [127:0] state_reg;
    logic [3:0]   round_cnt;
    logic [127:0] round_out;
    logic [127:0] whiten_key;
    logic         accept;
    logic         capture_keys;
    logic         final_round;

    assign accept       = pt_valid_i & pt_ready_o;
    assign capture_keys = (state == IDLE_S) & round_keys_valid_i;
    assign final_round  = (round_cnt == LAST_ROUND);

    // Keys arriving in the same cycle as the plaintext are used directly, so
    // the whitening step does not wait for the store to update.
    assign whiten_key = round_keys_valid_i ? round_keys_i[0] : key_store[0];

    aes_enc_round u_round (
        .state       (state_reg),
        .round_key   (key_store[round_cnt]),
        .final_round (final_round),
        .next_state  (round_out)
    );

    // ---------------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------------
    // NOTE: every clocked block uses non-blocking assignments so all
    // registers update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE_S;
        end else begin
            state <= state_next;
        end
    end

    // ---------------------------------------------------------------------
    // FSM next-state and output decode
    // ---------------------------------------------------------------------
    // NOTE: defaults are assigned first so no path through the block leaves
    // an output unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        pt_ready_o = 1'b0;
        ct_valid_o = 1'b0;
        busy_o     = 1'b1;
        unique case (state)
            IDLE_S: begin
                busy_o     = 1'b0;
                pt_ready_o = keys_loaded;
                if (accept) begin
                    state_next = ROUND_S;
                end
            end
            ROUND_S: begin
                if (final_round) begin
`ifdef AES_ENC_OUT_REG_EN
                    state_next = OUTREG_S;
`else
                    state_next = OUT_S;
`endif
                end
            end
            OUTREG_S: begin
                state_next = OUT_S;
            end
            OUT_S: begin
                ct_valid_o = 1'b1;
                if (ct_ready_i) begin
                    state_next = IDLE_S;
                end
            end
            default: begin
                state_next = IDLE_S;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Round key store
    // ---------------------------------------------------------------------
    // NOTE: the 15x128 key store has no reset; keys_loaded alone gates its
    // use, so stale contents after reset can never reach a block.
    always_ff @(posedge clk) begin
        if (capture_keys) begin
            key_store <= round_keys_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            keys_loaded <= 1'b0;
        end else if (capture_keys) begin
            keys_loaded <= 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Cipher state and round counter
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg <= '0;
            round_cnt <= '0;
        end else if (accept) begin
            state_reg <= pt_data_i ^ whiten_key;
            round_cnt <= 4'd1;
        end else if (state == ROUND_S) begin
            state_reg <= round_out;
            // Wrap to 0 after the final round so the counter stays within 0..14.
            round_cnt <= final_round ? 4'd0 : round_cnt + 4'd1;
        end
    end

    // ---------------------------------------------------------------------
    // Ciphertext output
    // ---------------------------------------------------------------------
`ifdef AES_ENC_OUT_REG_EN
    logic [127:0] ct_reg;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ct_reg <= '0;
        end else if (state == OUTREG_S) begin
            ct_reg <= state_reg;
        end
    end

    assign ct_data_o = ct_reg;
`else
    // state_reg is frozen outside ROUND_S, so it holds the ciphertext for as
    // long as OUT_S lasts.
    assign ct_data_o = state_reg;
`endif

endmodule

// File: tb/tb_aes256_encrypt_core.sv
// ---------------------------------------------------------------------------
// tb_aes256_encrypt_core
//
// Self-checking bench for aes256_encrypt_core. A reference AES-256 model
// (S-box derived from GF(2^8) inversion plus the affine map, key expansion,
// matrix-form MixColumns) produces expected ciphertexts; a scoreboard queue
// holds them with their expected arrival cycle, and a monitor compares every
// ciphertext the core presents. Honors AES_ENC_OUT_REG_EN for latency.
// ---------------------------------------------------------------------------
module tb_aes256_encrypt_core;
    import aes256_encrypt_core_pkg::*;

`ifdef AES_ENC_OUT_REG_EN
    localparam int LAT = 16;
`else
    localparam int LAT = 15;
`endif

    localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] ZERO_CT = 128'hdc95c078a2408989ad48a21492842087;

    logic         clk = 1'b0;
    logic         resetn;
    round_keys_t  round_keys_i;
    logic         round_keys_valid_i;
    logic [127:0] pt_data_i;
    logic         pt_valid_i;
    logic         pt_ready_o;
    logic [127:0] ct_data_o;
    logic         ct_valid_o;
    logic         ct_ready_i;
    logic         busy_o;

    logic rand_ready  = 1'b0;
    logic ready_force = 1'b1;
    logic rand_bit    = 1'b0;

    assign ct_ready_i = rand_ready ? rand_bit : ready_force;

    always #5 clk = ~clk;

    aes256_encrypt_core #(.NUM_ROUNDS(14), .DATA_WIDTH(128)) dut (
        .clk                (clk),
        .resetn             (resetn),
        .round_keys_i       (round_keys_i),
        .round_keys_valid_i (round_keys_valid_i),
        .pt_data_i          (pt_data_i),
        .pt_valid_i         (pt_valid_i),
        .pt_ready_o         (pt_ready_o),
        .ct_data_o          (ct_data_o),
        .ct_valid_o         (ct_valid_o),
        .ct_ready_i         (ct_ready_i),
        .busy_o             (busy_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [127:0] data;
        int           due;
    } exp_t;

    exp_t exp_q[$];
    logic [7:0] sbox_ref [256];

    always @(posedge clk) cyc = cyc + 1;

    always @(posedge clk) begin
        #1;
        rand_bit = 1'($urandom_range(0, 1));
    end

    // ------------------------------------------------------------------ checks
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        checkb({tag, "_pt_ready"}, pt_ready_o, 1'b0);
        checkb({tag, "_ct_valid"}, ct_valid_o, 1'b0);
        checkb({tag, "_busy"}, busy_o, 1'b0);
        check({tag, "_ct_data"}, ct_data_o, 128'h0);
    endtask

    // --------------------------------------------------------- reference model
    function automatic logic [7:0] gf_mul_ref(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return 8'((v << n) | (v >> (8 - n)));
    endfunction

    // S(x) = affine(x^-1), with x^-1 = x^254 and 0 mapped to 0.
    function automatic logic [7:0] sbox_entry(input int x);
        logic [7:0] inv;
        logic [7:0] b;
        b   = 8'(x);
        inv = (x == 0) ? 8'h00 : 8'h01;
        if (x != 0) begin
            for (int k = 0; k < 254; k++) inv = gf_mul_ref(inv, b);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_ref[w[31:24]], sbox_ref[w[23:16]], sbox_ref[w[15:8]], sbox_ref[w[7:0]]};
    endfunction

    function automatic round_keys_t expand_key(input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        round_keys_t rk;
        rcon = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = gf_mul_ref(rcon, 8'h02);
            end else if (i % 8 == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rk;
    endfunction

    function automatic logic [127:0] aes256_ref(input logic [255:0] key, input logic [127:0] pt);
        round_keys_t  rk;
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   coef [4];
        logic [127:0] out;
        coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        rk = expand_key(key);
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[0][127-8*i -: 8];
        for (int rnd = 1; rnd <= 14; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_ref[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[r+4*c] = t[r + 4*((c + r) % 4)];
            if (rnd != 14) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) begin
                        t[r+4*c] = 8'h00;
                        for (int k = 0; k < 4; k++)
                            t[r+4*c] = t[r+4*c] ^ gf_mul_ref(coef[(k - r + 4) % 4], s[k+4*c]);
                    end
                end
                s = t;
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[rnd][127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
        return out;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ----------------------------------------------------------------- monitor
    exp_t cur;
    logic prev_valid = 1'b0;

    always @(negedge clk) begin
        if (resetn === 1'b1 && ct_valid_o === 1'b1) begin
            if (!prev_valid) begin
                if (exp_q.size() == 0) begin
                    checkb("ct_unexpected", ct_valid_o, 1'b0);
                end else begin
                    cur = exp_q.pop_front();
                    check("ct_data", ct_data_o, cur.data);
                    check("ct_latency", 128'(cyc), 128'(cur.due));
                end
            end else begin
                check("ct_stable", ct_data_o, cur.data);
            end
            checkb("pt_ready_in_out", pt_ready_o, 1'b0);
        end
        prev_valid = (resetn === 1'b1) && (ct_valid_o === 1'b1);
    end

    // ------------------------------------------------------------ driver tasks
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic present_keys(input logic [255:0] key);
        round_keys_i       = expand_key(key);
        round_keys_valid_i = 1'b1;
        wait_cycles(1);
        round_keys_valid_i = 1'b0;
    endtask

    // Offers one block; the expected ciphertext and arrival cycle are queued
    // at the cycle the handshake happens.
    task automatic send_pt(input logic [127:0] pt, input logic [127:0] exp_ct);
        int waited;
        exp_t e;
        waited     = 0;
        pt_data_i  = pt;
        pt_valid_i = 1'b1;
        @(negedge clk);
        while (!pt_ready_o && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!pt_ready_o) begin
            checkb("pt_accept_timeout", pt_ready_o, 1'b1);
        end else begin
            e.data = exp_ct;
            e.due  = cyc + LAT;
            exp_q.push_back(e);
        end
        wait_cycles(1);
        pt_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || ct_valid_o) && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 128'(exp_q.size()), 128'h0);
        wait_cycles(1);
    endtask

    // --------------------------------------------------------------- stimulus
    initial begin
        logic [255:0] model_key;
        logic [127:0] pt;
        int           bad;
        int           n;

        for (int x = 0; x < 256; x++) sbox_ref[x] = sbox_entry(x);

        resetn             = 1'b0;
        round_keys_i       = '0;
        round_keys_valid_i = 1'b0;
        pt_data_i          = '0;
        pt_valid_i         = 1'b0;
        model_key          = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        wait_cycles(1);
        resetn = 1'b1;

        // Plaintext offered with no keys ever loaded must be refused.
        pt_data_i  = rand128();
        pt_valid_i = 1'b1;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (pt_ready_o || ct_valid_o) bad++;
        end
        pt_valid_i = 1'b0;
        check("no_keys_refused", 128'(bad), 128'h0);
        wait_cycles(1);

        // FIPS-197 C.3 and the all-zero vector.
        model_key = C3_KEY;
        present_keys(model_key);
        send_pt(C3_PT, C3_CT);
        wait_drain();

        model_key = '0;
        present_keys(model_key);
        send_pt(128'h0, ZERO_CT);
        wait_drain();

        // Sink stalls for 5 cycles after ct_valid_o rises.
        ready_force = 1'b0;
        pt = rand128();
        send_pt(pt, aes256_ref(model_key, pt));
        n = 0;
        while (!ct_valid_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkb("stall_valid_seen", ct_valid_o, 1'b1);
        repeat (5) @(negedge clk);
        wait_cycles(0);
        ready_force = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkb("post_stall_ct_valid", ct_valid_o, 1'b0);
        checkb("post_stall_busy", busy_o, 1'b0);
        checkb("post_stall_pt_ready", pt_ready_o, 1'b1);
        wait_cycles(1);

        // New keys presented mid-block only affect the next block.
        model_key = '0;
        present_keys(model_key);
        send_pt(C3_PT, aes256_ref(model_key, C3_PT));
        wait_cycles(3);
        round_keys_i       = expand_key(C3_KEY);
        round_keys_valid_i = 1'b1;
        wait_drain();
        model_key = C3_KEY;
        send_pt(C3_PT, C3_CT);
        round_keys_valid_i = 1'b0;
        wait_drain();

        // Reset during round 7 discards the block and the keys.
        model_key = {rand128(), rand128()};
        present_keys(model_key);
        pt = rand128();
        send_pt(pt, aes256_ref(model_key, pt));
        wait_cycles(6);
        resetn = 1'b0;
        wait_cycles(1);
        exp_q.delete();
        resetn = 1'b1;
        @(negedge clk);
        check_outputs_zero("mid_reset");
        pt_valid_i = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (pt_ready_o || ct_valid_o) bad++;
        end
        pt_valid_i = 1'b0;
        check("after_reset_refused", 128'(bad), 128'h0);
        wait_cycles(1);
        present_keys(model_key);
        pt = rand128();
        send_pt(pt, aes256_ref(model_key, pt));
        wait_drain();

        // Random back-to-back traffic with random sink stalls; some blocks
        // bring fresh keys in the same cycle as the plaintext.
        rand_ready = 1'b1;
        for (int b = 0; b < 12; b++) begin
            pt = rand128();
            if ($urandom_range(0, 2) == 0) begin
                model_key          = {rand128(), rand128()};
                round_keys_i       = expand_key(model_key);
                round_keys_valid_i = 1'b1;
            end
            send_pt(pt, aes256_ref(model_key, pt));
            round_keys_valid_i = 1'b0;
        end
        wait_drain();
        rand_ready = 1'b0;
        wait_cycles(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
